// File: rtl/paillier_keygen_stream.sv
// paillier_keygen_stream
// Batch Paillier key-component generator. A p/q store is loaded by the host;
// on start, entries 0..eff_count-1 are read one at a time, validated, and
// multiplied with an iterative radix-2**MULT_DIGIT shift-add multiplier.
// Each entry produces n = p*q, g = n+1 and phi = (p-1)*(q-1). Results are
// streamed out over a valid/ready handshake.
//
// Ports:
//   clock, reset         rising-edge clock, asynchronous active-high reset
//   pq_wr_en/addr, p_din, q_din   store write port (ignored while busy)
//   start, count         batch start (accepted in IDLE) and entry count
//   busy, done           batch in progress / one-cycle completion pulse
//   batch_err            sticky: some entry of the batch failed validation
//   out_valid/out_ready  result handshake
//   out_idx, out_n, out_g, out_phi, out_err   result payload
module paillier_keygen_stream #(
    parameter int DATA_WIDTH     = 1024,
    parameter int RAM_ADDR_WIDTH = 5,
    parameter int MULT_DIGIT     = 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      pq_wr_en,
    input  logic [RAM_ADDR_WIDTH-1:0] pq_wr_addr,
    input  logic [DATA_WIDTH/2-1:0]   p_din,
    input  logic [DATA_WIDTH/2-1:0]   q_din,
    input  logic                      start,
    input  logic [RAM_ADDR_WIDTH:0]   count,
    output logic                      busy,
    output logic                      done,
    output logic                      batch_err,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [RAM_ADDR_WIDTH-1:0] out_idx,
    output logic [DATA_WIDTH-1:0]     out_n,
    output logic [DATA_WIDTH-1:0]     out_g,
    output logic [DATA_WIDTH-1:0]     out_phi,
    output logic                      out_err
);

    localparam int HALF       = DATA_WIDTH / 2;
    localparam int DEPTH      = 2 ** RAM_ADDR_WIDTH;
    localparam int MUL_CYCLES = HALF / MULT_DIGIT;
    localparam int CNT_W      = $clog2(MUL_CYCLES + 1);

    localparam logic [RAM_ADDR_WIDTH:0]   DEPTH_C  = {1'b1, {RAM_ADDR_WIDTH{1'b0}}};
    localparam logic [RAM_ADDR_WIDTH:0]   CNT_ZERO = {(RAM_ADDR_WIDTH+1){1'b0}};
    localparam logic [RAM_ADDR_WIDTH-1:0] IDX_ZERO = {RAM_ADDR_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0]     D_ZERO   = {DATA_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0]     D_ONE    = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [HALF-1:0]           H_THREE  = HALF'(3);
    localparam logic [CNT_W-1:0]          MUL_LAST = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0]          MUL_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_LD   = 3'd2,
        S_MUL  = 3'd3,
        S_FIN  = 3'd4,
        S_OUT  = 3'd5,
        S_DONE = 3'd6
    } state_t;

    state_t                    state_r;
    logic [HALF-1:0]           p_mem_r [DEPTH];
    logic [HALF-1:0]           q_mem_r [DEPTH];
    logic [HALF-1:0]           rd_p_r;
    logic [HALF-1:0]           rd_q_r;
    logic [HALF-1:0]           p_r;
    logic [HALF-1:0]           q_r;
    logic                      err_r;
    logic [DATA_WIDTH-1:0]     acc_r;
    logic [DATA_WIDTH-1:0]     mcand_r;
    logic [HALF-1:0]           mplier_r;
    logic [CNT_W-1:0]          cnt_r;
    logic [RAM_ADDR_WIDTH-1:0] idx_r;
    logic [RAM_ADDR_WIDTH:0]   eff_count_r;
    logic                      busy_r;
    logic                      done_r;
    logic                      batch_err_r;
    logic                      out_valid_r;
    logic [RAM_ADDR_WIDTH-1:0] out_idx_r;
    logic [DATA_WIDTH-1:0]     out_n_r;
    logic [DATA_WIDTH-1:0]     out_g_r;
    logic [DATA_WIDTH-1:0]     out_phi_r;
    logic                      out_err_r;

    logic [MULT_DIGIT-1:0]     digit_s;
    logic [DATA_WIDTH-1:0]     partial_s;
    logic [DATA_WIDTH-1:0]     acc_next_s;
    logic [DATA_WIDTH-1:0]     phi_s;
    logic [DATA_WIDTH-1:0]     g_s;
    logic                      ld_err_s;
    logic [RAM_ADDR_WIDTH:0]   eff_count_s;
    logic [RAM_ADDR_WIDTH:0]   idx_next_s;
    logic                      last_entry_s;

    // Store write port; the host may not modify entries during a batch.
    always_ff @(posedge clock) begin
        if (pq_wr_en && !busy_r) begin
            p_mem_r[pq_wr_addr] <= p_din;
            q_mem_r[pq_wr_addr] <= q_din;
        end
    end

    // Registered store read of the current entry address.
    always_ff @(posedge clock) begin
        rd_p_r <= p_mem_r[idx_r];
        rd_q_r <= q_mem_r[idx_r];
    end

    // Datapath: one multiplier digit step, result forms, validation, indexing.
    always_comb begin
        digit_s    = mplier_r[MULT_DIGIT-1:0];
        partial_s  = mcand_r * {{(DATA_WIDTH-MULT_DIGIT){1'b0}}, digit_s};
        acc_next_s = acc_r + partial_s;
        // (p-1)(q-1) = pq - p - q + 1; wraps harmlessly for rejected entries
        phi_s      = acc_r - {{HALF{1'b0}}, p_r} - {{HALF{1'b0}}, q_r} + D_ONE;
        g_s        = acc_r + D_ONE;
        ld_err_s   = (rd_p_r == rd_q_r) || !rd_p_r[0] || !rd_q_r[0] ||
                     (rd_p_r < H_THREE) || (rd_q_r < H_THREE);
        if (count > DEPTH_C) begin
            eff_count_s = DEPTH_C;
        end else begin
            eff_count_s = count;
        end
        idx_next_s   = {1'b0, idx_r} + {{RAM_ADDR_WIDTH{1'b0}}, 1'b1};
        last_entry_s = !(idx_next_s < eff_count_r);
    end

    // Batch control FSM together with the multiplier and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r     <= S_IDLE;
            p_r         <= {HALF{1'b0}};
            q_r         <= {HALF{1'b0}};
            err_r       <= 1'b0;
            acc_r       <= D_ZERO;
            mcand_r     <= D_ZERO;
            mplier_r    <= {HALF{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            idx_r       <= IDX_ZERO;
            eff_count_r <= CNT_ZERO;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            batch_err_r <= 1'b0;
            out_valid_r <= 1'b0;
            out_idx_r   <= IDX_ZERO;
            out_n_r     <= D_ZERO;
            out_g_r     <= D_ZERO;
            out_phi_r   <= D_ZERO;
            out_err_r   <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        eff_count_r <= eff_count_s;
                        batch_err_r <= 1'b0;
                        idx_r       <= IDX_ZERO;
                        if (eff_count_s == CNT_ZERO) begin
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            state_r <= S_DONE;
                        end else begin
                            busy_r  <= 1'b1;
                            state_r <= S_RD;
                        end
                    end
                end
                S_RD: begin
                    state_r <= S_LD;
                end
                S_LD: begin
                    p_r      <= rd_p_r;
                    q_r      <= rd_q_r;
                    err_r    <= ld_err_s;
                    acc_r    <= D_ZERO;
                    mcand_r  <= {{HALF{1'b0}}, rd_p_r};
                    mplier_r <= rd_q_r;
                    cnt_r    <= {CNT_W{1'b0}};
                    state_r  <= S_MUL;
                end
                S_MUL: begin
                    // Rejected entries still run the multiplier to keep latency fixed.
                    acc_r    <= acc_next_s;
                    mcand_r  <= mcand_r << MULT_DIGIT;
                    mplier_r <= mplier_r >> MULT_DIGIT;
                    cnt_r    <= cnt_r + MUL_ONE;
                    if (cnt_r == MUL_LAST) begin
                        state_r <= S_FIN;
                    end
                end
                S_FIN: begin
                    out_idx_r   <= idx_r;
                    out_valid_r <= 1'b1;
                    if (err_r) begin
                        out_n_r     <= D_ZERO;
                        out_g_r     <= D_ZERO;
                        out_phi_r   <= D_ZERO;
                        out_err_r   <= 1'b1;
                        batch_err_r <= 1'b1;
                    end else begin
                        out_n_r     <= acc_r;
                        out_g_r     <= g_s;
                        out_phi_r   <= phi_s;
                        out_err_r   <= 1'b0;
                    end
                    state_r <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        if (last_entry_s) begin
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            state_r <= S_DONE;
                        end else begin
                            idx_r   <= idx_next_s[RAM_ADDR_WIDTH-1:0];
                            state_r <= S_RD;
                        end
                    end
                end
                S_DONE: begin
                    done_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    busy_r      <= 1'b0;
                    done_r      <= 1'b0;
                    out_valid_r <= 1'b0;
                    state_r     <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign batch_err = batch_err_r;
    assign out_valid = out_valid_r;
    assign out_idx   = out_idx_r;
    assign out_n     = out_n_r;
    assign out_g     = out_g_r;
    assign out_phi   = out_phi_r;
    assign out_err   = out_err_r;

endmodule

// File: tb/tb_paillier_keygen_stream.sv
// Directed testbench for paillier_keygen_stream (16-bit data, 32-entry store).
// dut1 uses MULT_DIGIT=1, dut4 uses MULT_DIGIT=4.
module tb_paillier_keygen_stream;

    localparam int DW   = 16;
    localparam int AW   = 5;
    localparam int HALF = 8;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset;

    logic          pq_wr_en, start, busy, done, batch_err, out_valid, out_ready, out_err;
    logic [AW-1:0] pq_wr_addr, out_idx;
    logic [HALF-1:0] p_din, q_din;
    logic [AW:0]   count;
    logic [DW-1:0] out_n, out_g, out_phi;

    logic          pq_wr_en4, start4, busy4, done4, batch_err4, out_valid4, out_ready4, out_err4;
    logic [AW-1:0] pq_wr_addr4, out_idx4;
    logic [HALF-1:0] p_din4, q_din4;
    logic [AW:0]   count4;
    logic [DW-1:0] out_n4, out_g4, out_phi4;

    paillier_keygen_stream #(.DATA_WIDTH(DW), .RAM_ADDR_WIDTH(AW), .MULT_DIGIT(1)) dut1 (
        .clock(clock), .reset(reset), .pq_wr_en(pq_wr_en), .pq_wr_addr(pq_wr_addr),
        .p_din(p_din), .q_din(q_din), .start(start), .count(count), .busy(busy),
        .done(done), .batch_err(batch_err), .out_valid(out_valid), .out_ready(out_ready),
        .out_idx(out_idx), .out_n(out_n), .out_g(out_g), .out_phi(out_phi), .out_err(out_err)
    );

    paillier_keygen_stream #(.DATA_WIDTH(DW), .RAM_ADDR_WIDTH(AW), .MULT_DIGIT(4)) dut4 (
        .clock(clock), .reset(reset), .pq_wr_en(pq_wr_en4), .pq_wr_addr(pq_wr_addr4),
        .p_din(p_din4), .q_din(q_din4), .start(start4), .count(count4), .busy(busy4),
        .done(done4), .batch_err(batch_err4), .out_valid(out_valid4), .out_ready(out_ready4),
        .out_idx(out_idx4), .out_n(out_n4), .out_g(out_g4), .out_phi(out_phi4), .out_err(out_err4)
    );

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int hs_cnt = 0;
    int vld_cnt = 0;

    logic [DW-1:0] exp_n   [32];
    logic [DW-1:0] exp_g   [32];
    logic [DW-1:0] exp_phi [32];
    logic          exp_err [32];

    // Event counters for dut1
    always @(posedge clock) begin
        if (done === 1'b1) done_cnt++;
        if (out_valid === 1'b1 && out_ready === 1'b1) hs_cnt++;
        if (out_valid === 1'b1) vld_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Write dut1 store and record the reference result for that entry.
    task automatic set_entry(input int idx, input int p, input int q);
        logic bad;
        pq_wr_en = 1'b1; pq_wr_addr = AW'(idx); p_din = HALF'(p); q_din = HALF'(q);
        tick();
        pq_wr_en = 1'b0;
        bad = (p == q) || (p % 2 == 0) || (q % 2 == 0) || (p < 3) || (q < 3);
        exp_err[idx] = bad;
        exp_n[idx]   = bad ? 16'h0000 : DW'(p * q);
        exp_g[idx]   = bad ? 16'h0000 : DW'(p * q + 1);
        exp_phi[idx] = bad ? 16'h0000 : DW'((p - 1) * (q - 1));
    endtask

    task automatic start_batch(input int cnt);
        count = (AW+1)'(cnt);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 200) begin
            tick();
            cyc++;
        end
        chk("valid_timeout", {31'd0, out_valid}, 32'd1);
    endtask

    // Receive n results with out_ready high, checking against the reference.
    task automatic collect(input int n, output int lat0);
        int cyc;
        lat0 = 0;
        for (int k = 0; k < n; k++) begin
            wait_valid(cyc);
            if (k == 0) lat0 = cyc;
            chk("idx", {27'd0, out_idx}, k);
            chk("n", {16'd0, out_n}, {16'd0, exp_n[k]});
            chk("g", {16'd0, out_g}, {16'd0, exp_g[k]});
            chk("phi", {16'd0, out_phi}, {16'd0, exp_phi[k]});
            chk("err", {31'd0, out_err}, {31'd0, exp_err[k]});
            tick();
        end
    endtask

    initial begin
        int lat, d0, h0, v0, cyc;
        logic [DW-1:0] sn, sg, sp;

        reset = 1'b1;
        pq_wr_en = 1'b0; pq_wr_addr = 5'd0; p_din = 8'd0; q_din = 8'd0;
        start = 1'b0; count = 6'd0; out_ready = 1'b1;
        pq_wr_en4 = 1'b0; pq_wr_addr4 = 5'd0; p_din4 = 8'd0; q_din4 = 8'd0;
        start4 = 1'b0; count4 = 6'd0; out_ready4 = 1'b1;
        tick(); tick();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_n", {16'd0, out_n}, 32'd0);
        chk("rst_phi", {16'd0, out_phi}, 32'd0);
        reset = 1'b0;
        tick();

        // Test 1: single entry, latency and hand-computed values
        set_entry(0, 11, 13);
        d0 = done_cnt;
        start_batch(1);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        wait_valid(lat);
        chk("t1_latency", lat, 32'd11);
        chk("t1_n", {16'd0, out_n}, 32'h008F);
        chk("t1_g", {16'd0, out_g}, 32'h0090);
        chk("t1_phi", {16'd0, out_phi}, 32'h0078);
        chk("t1_idx", {27'd0, out_idx}, 32'd0);
        chk("t1_err", {31'd0, out_err}, 32'd0);
        tick();
        chk("t1_valid_drop", {31'd0, out_valid}, 32'd0);
        chk("t1_done", {31'd0, done}, 32'd1);
        chk("t1_busy_end", {31'd0, busy}, 32'd0);
        tick(); tick();
        chk("t1_done_once", done_cnt - d0, 32'd1);
        chk("t1_batch_err", {31'd0, batch_err}, 32'd0);

        // Test 2: three entries, third invalid
        set_entry(1, 251, 241);
        set_entry(2, 7, 7);
        start_batch(3);
        collect(3, lat);
        chk("t2_latency", lat, 32'd11);
        chk("t2_done", {31'd0, done}, 32'd1);
        chk("t2_batch_err", {31'd0, batch_err}, 32'd1);
        tick();

        // Test 3: back-pressure holds the result stable
        set_entry(0, 251, 241);
        chk("t3_batch_err_kept", {31'd0, batch_err}, 32'd1);
        out_ready = 1'b0;
        h0 = hs_cnt;
        start_batch(1);
        chk("t3_batch_err_clr", {31'd0, batch_err}, 32'd0);
        wait_valid(lat);
        sn = out_n; sg = out_g; sp = out_phi;
        chk("t3_n", {16'd0, sn}, 32'h0000EC4B);
        chk("t3_g", {16'd0, sg}, 32'h0000EC4C);
        chk("t3_phi", {16'd0, sp}, 32'h0000EA60);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("t3_hold_valid", {31'd0, out_valid}, 32'd1);
            chk("t3_hold_n", {16'd0, out_n}, {16'd0, sn});
            chk("t3_hold_g", {16'd0, out_g}, {16'd0, sg});
            chk("t3_hold_phi", {16'd0, out_phi}, {16'd0, sp});
        end
        out_ready = 1'b1;
        tick();
        chk("t3_valid_drop", {31'd0, out_valid}, 32'd0);
        tick(); tick(); tick();
        chk("t3_one_hs", hs_cnt - h0, 32'd1);

        // Test 4a: count = 0 completes without results
        v0 = vld_cnt;
        start_batch(0);
        chk("t4_zero_done", {31'd0, done}, 32'd1);
        tick(); tick();
        chk("t4_zero_done_clr", {31'd0, done}, 32'd0);
        chk("t4_zero_novalid", vld_cnt - v0, 32'd0);

        // Test 4b: count = 40 clamps to 32 entries
        for (int i = 0; i < 32; i++) begin
            if (i == 10) set_entry(i, 25, 25);
            else set_entry(i, 2 * i + 3, 2 * i + 5);
        end
        h0 = hs_cnt;
        start_batch(40);
        collect(32, lat);
        chk("t4_done", {31'd0, done}, 32'd1);
        chk("t4_batch_err", {31'd0, batch_err}, 32'd1);
        tick(); tick();
        chk("t4_hs_count", hs_cnt - h0, 32'd32);

        // Test 5: MULT_DIGIT=4 instance
        pq_wr_en4 = 1'b1; pq_wr_addr4 = 5'd0; p_din4 = 8'd11; q_din4 = 8'd13;
        tick();
        pq_wr_en4 = 1'b0;
        count4 = 6'd1; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        cyc = 0;
        while (out_valid4 !== 1'b1 && cyc < 100) begin
            tick();
            cyc++;
        end
        chk("t5_latency", cyc, 32'd5);
        chk("t5_n", {16'd0, out_n4}, 32'h008F);
        chk("t5_g", {16'd0, out_g4}, 32'h0090);
        chk("t5_phi", {16'd0, out_phi4}, 32'h0078);
        chk("t5_err", {31'd0, out_err4}, 32'd0);
        tick();
        chk("t5_done", {31'd0, done4}, 32'd1);

        // Test 6a: writes and start while busy are ignored
        set_entry(0, 11, 13);
        d0 = done_cnt; h0 = hs_cnt;
        start_batch(1);
        tick(); tick(); tick(); tick();
        pq_wr_en = 1'b1; pq_wr_addr = 5'd0; p_din = 8'd7; q_din = 8'd7;
        count = 6'd0; start = 1'b1;
        tick();
        pq_wr_en = 1'b0; start = 1'b0;
        chk("t6_busy_held", {31'd0, busy}, 32'd1);
        collect(1, lat);
        tick(); tick();
        chk("t6_one_done", done_cnt - d0, 32'd1);
        chk("t6_one_hs", hs_cnt - h0, 32'd1);

        // Test 6b: reset in the middle of MUL
        d0 = done_cnt;
        start_batch(1);
        tick(); tick(); tick();
        reset = 1'b1;
        #1;
        chk("t6_rst_busy", {31'd0, busy}, 32'd0);
        chk("t6_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("t6_rst_n", {16'd0, out_n}, 32'd0);
        chk("t6_rst_g", {16'd0, out_g}, 32'd0);
        chk("t6_rst_err", {31'd0, out_err}, 32'd0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        chk("t6_no_done", done_cnt - d0, 32'd0);
        chk("t6_idle_valid", {31'd0, out_valid}, 32'd0);

        // Store content survives both the dropped write and the reset
        start_batch(1);
        collect(1, lat);
        chk("t6_rerun_latency", lat, 32'd11);
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/paillier_keygen_stream.md
Name: paillier_keygen_stream

Overview:
Batch Paillier public/private key-component generator with an internal p/q store and a streamed result interface.
- Per entry computes n = p*q, g = n+1, phi = (p-1)*(q-1) using a parametrised-radix iterative multiplier.
- Adds a runtime entry count, per-entry input validation and valid/ready back-pressure.
- Sits between the host loader and the encryption/decryption key RAMs.

Parameters:
DATA_WIDTH, 1024, width of n/g/phi; p and q are DATA_WIDTH/2 bits (HALF).
RAM_ADDR_WIDTH, 5, p/q store depth = 2**RAM_ADDR_WIDTH.
MULT_DIGIT, 1, multiplier bits of q consumed per cycle; legal values 1, 2, 4; must divide HALF.

Ports:
clock  in  1  single clock, rising edge.
reset  in  1  asynchronous, active-high.
pq_wr_en  in  1  write p/q store.
pq_wr_addr  in  RAM_ADDR_WIDTH  store address.
p_din  in  HALF  p value.
q_din  in  HALF  q value.
start  in  1  begin batch; sampled only in IDLE.
count  in  RAM_ADDR_WIDTH+1  entries to process, starting at address 0.
busy  out  1  high from start accept until done.
done  out  1  one-cycle pulse after the batch completes.
batch_err  out  1  sticky: any entry in the batch failed validation.
out_valid  out  1  result valid.
out_ready  in  1  consumer accepts the result.
out_idx  out  RAM_ADDR_WIDTH  entry address of the result.
out_n  out  DATA_WIDTH  p*q.
out_g  out  DATA_WIDTH  n+1.
out_phi  out  DATA_WIDTH  (p-1)*(q-1).
out_err  out  1  entry failed validation.

Behaviour:
- Reset: FSM to IDLE; busy, done, batch_err, out_valid and out_err = 0; out_idx, out_n, out_g and out_phi = 0. Store contents are not cleared.
- Store: synchronous write; 1-cycle registered read. Writes while busy=1 are dropped.
- start in IDLE:
  - Latch eff_count = min(count, 2**RAM_ADDR_WIDTH).
  - Clear batch_err and set busy.
  - If eff_count == 0: go to DONE.
  - Otherwise set idx = 0 and go to RD.
  - start while busy is ignored.
- States:
  - IDLE: wait for start.
  - RD: drive the read address idx.
  - LD: register p and q. Validation error if p == q, p or q even, or p < 3 or q < 3. Clear the accumulator.
  - MUL: HALF/MULT_DIGIT cycles. Each cycle: acc += (q digit * p) << shift, where the digit is the least-significant MULT_DIGIT bits of the remaining q. Exactly full width, no truncation.
  - FIN: n = acc; phi = n - p - q + 1 (DATA_WIDTH modular arithmetic, exact for valid inputs); g = n + 1. On error, force n, g and phi to 0 and set out_err=1 and batch_err=1.
  - OUT: out_valid=1. All out_* stay stable until out_valid && out_ready. After the handshake:
    - idx+1 < eff_count: go to RD.
    - Otherwise: go to DONE.
  - DONE: done=1 for one cycle, busy=0, then IDLE.
- Latency:
  - With out_ready held high, out_valid rises exactly 3 + HALF/MULT_DIGIT cycles after the start-accept edge.
  - Each subsequent entry takes the same number of cycles after the previous handshake.
  - Error entries use the same latency (MUL still runs).
- Back-pressure: the FSM holds in OUT indefinitely. out_valid never drops without a handshake.
- out_valid deasserts the cycle after the handshake. Output data registers may change only when out_valid=0.
- Reset mid-operation: immediate IDLE with all outputs at reset values. No done pulse.
- batch_err stays set until the next accepted start.

Test Plan:
1. DATA_WIDTH=16, MULT_DIGIT=1; store[0] = p 11, q 13; count=1; out_ready=1 -> out_valid 11 cycles after start; out_n=0x008F, out_g=0x0090, out_phi=0x0078, out_idx=0, out_err=0; done pulses once; batch_err=0.
2. store[0]=11/13, store[1]=251/241, store[2]=7/7; count=3 -> in order: entry 1 gives n=0xEC4B, g=0xEC4C, phi=0xEA60; entry 2 gives n, g, phi = 0 with out_err=1; batch_err=1 after done.
3. Entry 1 setup from test 2 with out_ready low for 20 cycles after out_valid -> all out_* stable throughout; exactly one result accepted; same values as test 2.
4. count=0, then count=40 with RAM_ADDR_WIDTH=5 -> first: done within 2 cycles and no out_valid; second: exactly 32 handshakes, out_idx 0..31.
5. MULT_DIGIT=4 repeat of test 1 -> out_valid 5 cycles after start; identical results.
6. reset asserted mid-MUL; start pulsed while busy; pq_wr_en while busy -> reset gives all outputs 0, IDLE and no done; start while busy is ignored; writes while busy leave the store unchanged.
